seven_seg_scan_mux: RTL and testbench

//  Time-multiplexed driver for a common-anode multi-digit 7-segment display.

---
 rtl/seven_seg_pkg.sv | 31 +++
 rtl/hex_to_seg.sv | 11 +
 rtl/seven_seg_scan_mux.sv | 102 ++++++++++
 tb/tb_seven_seg_scan_mux.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment table, off pattern, scan states.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF_N = 7'h7F;

  // Active-high {A,B,C,D,E,F,G}; entry n sits at SEG_TABLE[n].
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1110011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with per-frame input snapshot.
// Define SEVEN_SEG_LZ_BLANK_EN to suppress leading zeros on digits above digit 0.
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n
);

  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]                slot_cnt, slot_next;
  logic [IDX_W-1:0]                 idx, idx_next;
  scan_state_e                      state, state_next;
  logic [NUM_DIGITS-1:0][3:0]       shadow_digits;
  logic [NUM_DIGITS-1:0]            shadow_en, shadow_dp, show_mask;
  logic [NUM_DIGITS-1:0]            an_d;
  logic [6:0]                       seg_d, seg_pattern;
  logic                             dp_d;

  hex_to_seg u_hex_to_seg (
    .nibble (shadow_digits[idx]),
    .seg    (seg_pattern)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic higher_zero;

  // Walk down from the top digit; a digit stays dark while it and everything above it is zero.
  always_comb begin
    show_mask   = shadow_en;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      higher_zero = higher_zero & (shadow_digits[k] == 4'h0);
      if (higher_zero) show_mask[k] = 1'b0;
    end
  end
`else
  assign show_mask = shadow_en;
`endif

  always_comb begin
    slot_next = slot_cnt + 1'b1;
    idx_next  = idx;
    if (slot_cnt == SLOT_LAST) begin
      slot_next = '0;
      idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    state_next = (slot_next < BLANK_END) ? ST_BLANK : ST_DRIVE;

    an_d  = '1;
    seg_d = SEG_OFF_N;
    dp_d  = 1'b1;
    if (state == ST_DRIVE && show_mask[idx]) begin
      an_d[idx] = 1'b0;
      seg_d     = ~seg_pattern;
      dp_d      = ~shadow_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt      <= '0;
      idx           <= '0;
      state         <= ST_BLANK;
      shadow_digits <= '0;
      shadow_en     <= '0;
      shadow_dp     <= '0;
      an_n          <= '1;
      seg_n         <= SEG_OFF_N;
      dp_n          <= 1'b1;
    end else begin
      slot_cnt <= slot_next;
      idx      <= idx_next;
      state    <= state_next;
      // Inputs are only sampled on the first cycle of a frame so a frame never tears.
      if (idx == '0 && slot_cnt == '0) begin
        shadow_digits <= digits_i;
        shadow_en     <= en_i;
        shadow_dp     <= dp_i;
      end
      an_n  <= an_d;
      seg_n <= seg_d;
      dp_n  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Self-checking bench for seven_seg_scan_mux using a cycle-position reference model.
module tb_seven_seg_scan_mux;

  localparam int N     = 4;
  localparam int S     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * S;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   digits = 16'h0000;
  logic [3:0]    en = 4'hF;
  logic [3:0]    dp = 4'h0;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [15:0] snap_digits = 16'h0;
  logic [3:0]  snap_en = 4'h0;
  logic [3:0]  snap_dp = 4'h0;
  logic [6:0]  seg_ref [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  seven_seg_scan_mux #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .digits_i (digits),
    .en_i     (en),
    .dp_i     (dp),
    .an_n     (an_n),
    .seg_n    (seg_n),
    .dp_n     (dp_n)
  );

  always #5 clk = ~clk;

  function automatic logic digit_visible(int d);
    logic upper_zero;
    if (!snap_en[d]) return 1'b0;
    if (LZ && d > 0) begin
      upper_zero = 1'b1;
      for (int j = d; j < N; j++)
        if (snap_digits[4*j +: 4] != 4'h0) upper_zero = 1'b0;
      if (upper_zero) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock edge; outputs after an edge reflect the scan position held just before it.
  task automatic tick_check();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         p, d, w;
    @(posedge clk);
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (rst) begin
      k = 0;
    end else begin
      p = k % FRAME;
      d = p / S;
      w = p % S;
      if (w >= B && digit_visible(d)) begin
        e_an[d] = 1'b0;
        e_seg   = ~seg_ref[snap_digits[4*d +: 4]];
        e_dp    = ~snap_dp[d];
      end
      if (p == 0) begin
        snap_digits = digits;
        snap_en     = en;
        snap_dp     = dp;
      end
      k++;
    end
    #1;
    checks++;
    assert (an_n === e_an) else begin
      errors++;
      $error("[TB] FAIL an_n k=%0d got %b expected %b", k, an_n, e_an);
    end
    checks++;
    assert (seg_n === e_seg) else begin
      errors++;
      $error("[TB] FAIL seg_n k=%0d got %h expected %h", k, seg_n, e_seg);
    end
    checks++;
    assert (dp_n === e_dp) else begin
      errors++;
      $error("[TB] FAIL dp_n k=%0d got %b expected %b", k, dp_n, e_dp);
    end
    checks++;
    assert ($countones(~an_n) <= 1) else begin
      errors++;
      $error("[TB] FAIL onehot k=%0d got %b expected at most one low", k, an_n);
    end
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) tick_check();
  endtask

  task automatic run_to(int target);
    for (int i = 0; i < FRAME && (k % FRAME) != target; i++) tick_check();
  endtask

  initial begin
    // Step 1: reset held, then release with zeros on all digits.
    rst = 1'b1; en = 4'hF; digits = 16'h0000; dp = 4'h0;
    run(3);
    rst = 1'b0;
    run(40);

    // Step 2: a full mixed-value pattern over two frames.
    digits = 16'h1A3F;
    run(2 * FRAME + 8);

    // Step 3: change inputs in the middle of the digit-1 drive window.
    run_to(S + 4);
    digits = 16'h2222;
    run(2 * FRAME);

    // Step 4: decimal point on digit 2 while digit 2 is disabled, then enabled.
    dp = 4'b0100; en = 4'b1011;
    run(2 * FRAME);
    en = 4'hF;
    run(FRAME + 4);

    // Step 5: reset pulse during the digit-2 drive window.
    digits = 16'h9C7E; dp = 4'b1001;
    run_to(2 * S + 4);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    digits = 16'h4B6D;
    run(FRAME + 10);

    // Step 6: leading zeros.
    digits = 16'h0050; en = 4'hF; dp = 4'h0;
    run(2 * FRAME + 4);
    digits = 16'h0000;
    run(FRAME + 4);

    // Step 7: random inputs with occasional reset pulses.
    for (int it = 0; it < 30; it++) begin
      digits = 16'($urandom);
      if ($urandom_range(0, 3) == 0) digits[15:8] = 8'h00;
      en = 4'($urandom);
      dp = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
      end
      run($urandom_range(1, 40));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
